// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, 2-entry fetch FIFO and IDLE/FETCH/HALTED control.
// Ports: clk/reset, fetch_en, PCAdress/Instruction_in, branch redirect, instr_* decode handshake, halted.
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [5:0]  PCAdress,
  input  logic [31:0] Instruction_in,
  input  logic        branch_valid,
  input  logic [5:0]  branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [5:0]  instr_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  pc;
  } ent_t;

  state_t     state_q, state_d;
  logic [5:0] pc_q, pc_d;
  ent_t       e0_q, e0_d;
  ent_t       e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       halted_q, halted_d;

  logic pop;
  logic push;
  logic is_halt;
  ent_t new_e;

  always_comb begin
    pop      = (cnt_q != 2'd0) && instr_ready;
    push     = (state_q == FETCH) && fetch_en && !branch_valid
               && ((cnt_q != 2'd2) || pop);
    new_e    = '{word: Instruction_in, pc: pc_q};
    is_halt  = (Instruction_in[31:26] == 6'h3f);
    state_d  = state_q;
    pc_d     = pc_q;
    e0_d     = e0_q;
    e1_d     = e1_q;
    cnt_d    = cnt_q;
    if (branch_valid) begin
      // Entries are left in place so instr_out/instr_pc keep their last value.
      cnt_d   = 2'd0;
      pc_d    = branch_target;
      state_d = fetch_en ? FETCH : IDLE;
    end else begin
      if (push) pc_d = pc_q + 6'd1;
      // e0 is always the head; a pop of the last entry leaves it untouched.
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = new_e;
          else               e1_d = new_e;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) e0_d = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = new_e;
          end else begin
            e0_d = e1_q;
            e1_d = new_e;
          end
        end
        default: ;
      endcase
      case (state_q)
        IDLE:    if (fetch_en) state_d = FETCH;
        FETCH: begin
          if (!fetch_en)            state_d = IDLE;
          else if (push && is_halt) state_d = HALTED;
        end
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= 6'd0;
      e0_q     <= '0;
      e1_q     <= '0;
      cnt_q    <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      e0_q     <= e0_d;
      e1_q     <= e1_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  assign PCAdress    = pc_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr_out   = e0_q.word;
  assign instr_pc    = e0_q.pc;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [5:0]  PCAdress;
  logic [31:0] Instruction_in;
  logic        branch_valid;
  logic [5:0]  branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [5:0]  instr_pc;
  logic        halted;

  logic [31:0] mem [64];

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  p;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   m_pc;
  int   m_st;
  int   total;
  int   bad;

  assign Instruction_in = mem[PCAdress];

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .PCAdress      (PCAdress),
    .Instruction_in(Instruction_in),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic        do_pop;
    logic        do_push;
    logic [31:0] w;
    if (reset) begin
      q.delete();
      m_pc = 0;
      m_st = 0;
      last = '0;
    end else if (branch_valid) begin
      q.delete();
      m_pc = int'(branch_target);
      m_st = fetch_en ? 1 : 0;
    end else begin
      w       = mem[m_pc];
      do_pop  = (q.size() > 0) && instr_ready;
      do_push = (m_st == 1) && fetch_en && ((q.size() < 2) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{w: w, p: 6'(m_pc)});
        m_pc = (m_pc + 1) % 64;
      end
      if (m_st == 0 && fetch_en) m_st = 1;
      else if (m_st == 1) begin
        if (!fetch_en) m_st = 0;
        else if (do_push && w[31:26] == 6'h3f) m_st = 2;
      end
    end
    if (q.size() > 0) last = q[0];
  endtask

  task automatic check_all();
    chk("valid", {31'd0, instr_valid}, {31'd0, q.size() > 0});
    chk("out", instr_out, last.w);
    chk("ipc", {26'd0, instr_pc}, {26'd0, last.p});
    chk("pc", {26'd0, PCAdress}, 32'(m_pc));
    chk("halted", {31'd0, halted}, {31'd0, m_st == 2});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h00200005;
    mem[1] = 32'h00400002;
    mem[2] = 32'h10640022;
    reset = 1'b1;
    fetch_en = 1'b0;
    branch_valid = 1'b0;
    branch_target = 6'd0;
    instr_ready = 1'b0;
    tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_out", instr_out, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // basic stream
    reset = 1'b0;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("s_first_invalid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("s_w0", instr_out, 32'h00200005);
    tick();
    chk("s_w1", instr_out, 32'h00400002);
    tick();
    chk("s_w2", instr_out, 32'h10640022);
    chk("s_p2", {26'd0, instr_pc}, 32'd2);
    tick();
    chk("s_w3", instr_out, 32'd0);
    chk("s_p3", {26'd0, instr_pc}, 32'd3);

    // backpressure
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr_ready = 1'b0;
    repeat (4) tick();
    chk("bp_pc", {26'd0, PCAdress}, 32'd2);
    chk("bp_out", instr_out, 32'h00200005);
    instr_ready = 1'b1;
    tick();
    chk("bp_p1", {26'd0, instr_pc}, 32'd1);
    tick();
    chk("bp_p2", {26'd0, instr_pc}, 32'd2);

    // PC wrap
    branch_valid = 1'b1;
    branch_target = 6'd62;
    tick();
    branch_valid = 1'b0;
    tick();
    chk("wrap_62", {26'd0, instr_pc}, 32'd62);
    tick();
    chk("wrap_63", {26'd0, instr_pc}, 32'd63);
    tick();
    chk("wrap_0", {26'd0, instr_pc}, 32'd0);

    // branch with full FIFO
    instr_ready = 1'b0;
    repeat (3) tick();
    branch_valid = 1'b1;
    branch_target = 6'd40;
    instr_ready = 1'b1;
    tick();
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_pc", {26'd0, PCAdress}, 32'd40);
    branch_valid = 1'b0;
    tick();
    chk("br_ipc", {26'd0, instr_pc}, 32'd40);

    // halt opcode
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[5] = 32'hFC000000;
    branch_valid = 1'b1;
    branch_target = 6'd0;
    tick();
    branch_valid = 1'b0;
    n = 0;
    while (!halted && n < 20) begin
      tick();
      n++;
    end
    chk("halt_seen", {31'd0, halted}, 32'd1);
    chk("halt_ipc", {26'd0, instr_pc}, 32'd5);
    chk("halt_pc", {26'd0, PCAdress}, 32'd6);
    repeat (3) tick();
    chk("halt_hold_pc", {26'd0, PCAdress}, 32'd6);
    chk("halt_drain", {31'd0, instr_valid}, 32'd0);
    branch_valid = 1'b1;
    tick();
    chk("unhalt", {31'd0, halted}, 32'd0);
    branch_valid = 1'b0;
    tick();
    chk("resume_ipc", {26'd0, instr_pc}, 32'd0);

    // reset over branch with full FIFO
    instr_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    branch_valid = 1'b1;
    branch_target = 6'd9;
    instr_ready = 1'b1;
    tick();
    chk("rb_pc", {26'd0, PCAdress}, 32'd0);
    chk("rb_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0;
    branch_valid = 1'b0;
    tick();
    chk("rb_idle", {31'd0, instr_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 7) == 0) mem[i][31:26] = 6'h3f;
      else if (mem[i][31:26] == 6'h3f) mem[i][31] = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      branch_valid = ($urandom_range(0, 15) == 0);
      branch_target = 6'($urandom);
      fetch_en = ($urandom_range(0, 5) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 fetch_en  input  1  level; 1 = fetching permitted.
REQ-005 PCAdress  output  6  word address to the instruction memory; equals the current PC register.
REQ-006 Instruction_in  input  32  word returned combinationally by the instruction memory for PCAdress, same cycle.
REQ-007 branch_valid  input  1  one-cycle redirect request.
REQ-008 branch_target  input  6  redirect address; valid when branch_valid=1.
REQ-009 instr_valid  output  1  FIFO head holds a word for decode.
REQ-010 instr_ready  input  1  decode accepts the head word this cycle.
REQ-011 instr_out  output  32  FIFO head instruction word.
REQ-012 instr_pc  output  6  address the head word was fetched from.
REQ-013 halted  output  1  1 while the state machine is in HALTED.

Function
REQ-014 The block SHALL contain a 2-entry FIFO of {word[31:0], pc[5:0]} pairs, a 6-bit PC register, and a state machine with states IDLE, FETCH and HALTED.
REQ-015 A pop SHALL occur on a rising edge where instr_valid=1 and instr_ready=1.
REQ-016 A push SHALL occur on a rising edge where all of the following hold: state=FETCH, fetch_en=1, branch_valid=0, and the FIFO is not full or a pop occurs on the same edge.
  - Pushed entry: {Instruction_in, PCAdress}.
REQ-017 On each push, PC SHALL advance by 1 modulo 64 (63 -> 0). With no push, PC SHALL hold.
REQ-018 Fetch latency: a word pushed on edge N SHALL appear on instr_out/instr_pc after edge N when the FIFO was empty before that edge.
REQ-019 Simultaneous push and pop on a full FIFO SHALL keep occupancy at 2 and preserve order.
REQ-020 Simultaneous push and pop on a 1-entry FIFO SHALL keep occupancy at 1 and preserve order.
REQ-021 When empty, instr_valid SHALL be 0 and instr_out/instr_pc SHALL hold their last values.
  - After reset with no push yet, instr_out/instr_pc SHALL be 0.
REQ-022 When branch_valid=1 on an edge, the following SHALL occur regardless of any other input:
  - the FIFO is flushed to empty;
  - PC <= branch_target;
  - no push occurs, and any simultaneous pop is discarded;
  - if fetch_en=1 the state becomes FETCH, otherwise IDLE.
REQ-023 State transitions (branch_valid=0):
  - IDLE -> FETCH when fetch_en=1.
  - FETCH -> IDLE when fetch_en=0.
  - FETCH -> HALTED on a push whose word has bits [31:26]=6'b111111 (halt opcode); the halt word itself is pushed and PC advances.
  - HALTED remains HALTED; it is left only by branch_valid or reset.
REQ-024 In IDLE and HALTED no push SHALL occur.
  - Pops continue, so the FIFO drains to decode.
REQ-025 halted SHALL be a registered output equal to 1 exactly when the state is HALTED.

Reset
REQ-026 On a reset edge the block SHALL set:
  - PC=0, FIFO empty, state=IDLE;
  - instr_valid=0, instr_out=0, instr_pc=0, halted=0.
REQ-027 Reset SHALL take priority over branch_valid, fetch_en and instr_ready.
REQ-028 A reset during fetching SHALL discard all FIFO contents without any pop being presented.

Verification
REQ-029 Memory model: addr0=32'h00200005, addr1=32'h00400002, addr2=32'h10640022, others 0.
  - Stimulus: reset, then fetch_en=1 and instr_ready=1 held.
  - Required: instr_out sequence 00200005, 00400002, 10640022, 0... with instr_pc 0, 1, 2, 3...; first instr_valid one cycle after entering FETCH.
REQ-030 instr_ready=0 with fetch_en=1 -> exactly 2 pushes; PCAdress stops at 2 with instr_out=00200005. Then instr_ready=1 -> words 0, 1, 2 delivered in order with no gap or duplicate.
REQ-031 PC reaches 63 -> next pushed entry has instr_pc=63, followed by instr_pc=0.
REQ-032 branch_valid=1, branch_target=6'd40 with the FIFO full and instr_ready=1 -> next cycle instr_valid=0 and PCAdress=40; the following cycle instr_pc=40.
REQ-033 Word 32'hFC000000 at address 5 -> it is pushed with instr_pc=5, halted=1, PCAdress stays 6, and no further pushes occur. A subsequent branch to 0 -> halted=0 and fetch resumes at 0.
REQ-034 reset asserted while the FIFO is full and branch_valid=1 -> next cycle PC=0, instr_valid=0, halted=0, state IDLE.
